fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Pop-side reader for the team's synchronous FIFO (push/pop/full/empty interface).
- Drains the FIFO's pop port and presents the data as a registered valid/ready stream to a downstream consumer.
- A 2-entry skid keeps `out_ready_i` off the FIFO pop path.
- Counts delivered words and supports a synchronous flush.
- Sits between the FIFO and any consumer that applies backpressure.

Parameters:
- DATA_W, 1, width of a FIFO word and of the stream data.
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_pop_data_i  input  DATA_W  FIFO head word. Show-ahead: valid whenever `fifo_empty_i`=0.
- fifo_pop_o  output  1  pop strobe to the FIFO. The head is consumed at the clock edge where it is 1.
- out_valid_o  output  1  stream valid.
- out_data_o  output  DATA_W  stream data, driven from a register.
- out_ready_i  input  1  stream ready from the consumer.
- flush_i  input  1  discard all buffered words; no pop in the same cycle.
- occupancy_o  output  2  number of words held in the skid (0..2).
- delivered_o  output  CNT_W  count of completed stream handshakes, wrapping.

Behaviour:
- Reset, synchronous and evaluated first:
  - state=EMPTY, occupancy_o=0, out_valid_o=0, out_data_o=0, delivered_o=0.
  - `fifo_pop_o`=0 during every cycle in which reset=1.
- `fifo_pop_o` = !reset && !flush_i && !fifo_empty_i && (occupancy < 2).
  - This is combinational from state and FIFO flags only; it never depends on `out_ready_i`.
- Pop latency: a word popped at edge N is visible on `out_data_o` with `out_valid_o`=1 from cycle N+1 if the skid was empty. Otherwise it queues behind the head.
- Handshake:
  - A transfer occurs on an edge where `out_valid_o` && `out_ready_i`.
  - `out_valid_o` = (occupancy != 0).
  - Once valid is asserted, `out_data_o` holds stable until the transfer, unless a flush occurs.
- State machine (state = occupancy). Notation: pop = `fifo_pop_o`, xfer = stream handshake.
  - EMPTY: pop → ONE (head <= fifo data); else stay.
  - ONE: pop & !xfer → TWO (tail <= fifo data). pop & xfer → ONE (head <= fifo data). !pop & xfer → EMPTY. Neither → stay.
  - TWO: pop is impossible. xfer → ONE (head <= tail). Else stay.
- Ordering: words appear on the stream in exactly FIFO order. No duplication, no loss except via flush.
- Flush:
  - Next state is EMPTY regardless of handshake. `out_valid_o`=0 from the next cycle.
  - A handshake coinciding with flush still counts toward `delivered_o`, because the consumer took the data.
  - The FIFO itself is not flushed by this block.
- `delivered_o` increments by 1 per transfer and wraps from 2^CNT_W-1 to 0.
- FIFO going empty mid-stream: the skid drains normally and `out_valid_o` falls once occupancy reaches 0. There is no bubble insertion while words remain.
- Reset mid-operation: buffered words are dropped and the counter clears. The FIFO's own contents are untouched.
- X-safety: `fifo_pop_data_i` is sampled only on pop edges.

Decomposition:
- Package fifo_rd_stream_pkg holds:
  - `typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t`
  - localparam SKID_DEPTH = 2.
- Sub-module stream_skid2 (DATA_W parameter) implements the head/tail registers and state machine with in_valid/in_data/flush and out_valid/out_data/out_ready.
- fifo_rd_stream contains the pop logic, the counter, and one stream_skid2 instance.

Test Plan:
- Reset check: assert reset for 2 cycles with FIFO non-empty (data=1) → `fifo_pop_o`=0, `out_valid_o`=0, `delivered_o`=0 throughout. Pop first occurs the cycle reset drops.
- Single word: FIFO holds 1, `out_ready_i`=1 → `fifo_pop_o` pulses 1 cycle; `out_valid_o`=1, `out_data_o`=1 for exactly 1 cycle, one cycle after the pop; `delivered_o`=1.
- Backpressure: FIFO holds 1,0,1 (DATA_W=1), `out_ready_i`=0 → exactly 2 pops, occupancy_o=2, `out_data_o` stays 1. Raise ready → stream delivers 1,0,1 in order, third pop issued after the first transfer, `delivered_o`=3.
- Streaming: FIFO continuously non-empty, ready=1 for 10 cycles → one pop and one transfer per cycle after the first, occupancy_o steady at 1, `delivered_o`=9 or 10 per the timing above.
- Flush: occupancy=2, ready=0, assert flush_i 1 cycle → no pop that cycle; next cycle `out_valid_o`=0, occupancy_o=0. Popping resumes the following cycle with the next FIFO word.
- Counter wrap: CNT_W=2, perform 5 transfers → `delivered_o` sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO pop-side stream reader.
package fifo_rd_stream_pkg;

    // Skid occupancy doubles as the state encoding: EMPTY=0, ONE=1, TWO=2.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry skid buffer: head drives the stream, tail absorbs one extra word
// so the upstream accept decision never has to look at out_ready.
module stream_skid2
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    skid_state_t       state;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              xfer;

    assign xfer      = out_valid && out_ready;
    assign out_data  = head;
    assign occupancy = state;

    // Skid state machine: head/tail loading, drain on handshake, flush to empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            head      <= '0;
            tail      <= '0;
        end else if (flush) begin
            // Buffered words are abandoned; stale head is masked by valid=0.
            state     <= EMPTY;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        head      <= in_data;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_valid && !xfer) begin
                        tail  <= in_data;
                        state <= TWO;
                    end else if (in_valid && xfer) begin
                        head <= in_data;
                    end else if (xfer) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    // Upstream never offers a word while full.
                    if (xfer) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Pop-side reader: drains a show-ahead FIFO into a registered valid/ready
// stream through a 2-entry skid, counting delivered words.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_pop_data_i,
    output logic              fifo_pop_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              flush_i,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  delivered_o
);

    logic xfer;

    // Pop depends only on skid occupancy and FIFO flags, never on out_ready_i.
    assign fifo_pop_o = !reset && !flush_i && !fifo_empty_i
                        && (occupancy_o < 2'(SKID_DEPTH));

    assign xfer = out_valid_o && out_ready_i;

    stream_skid2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_i),
        .in_valid  (fifo_pop_o),
        .in_data   (fifo_pop_data_i),
        .out_valid (out_valid_o),
        .out_data  (out_data_o),
        .out_ready (out_ready_i),
        .occupancy (occupancy_o)
    );

    // Delivered-word counter; a handshake during flush still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            delivered_o <= '0;
        end else if (xfer) begin
            delivered_o <= delivered_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a queue-based show-ahead FIFO model.
module tb_fifo_rd_stream;

    logic       clk;
    logic       reset;
    logic       fifo_empty_i;
    logic [0:0] fifo_pop_data_i;
    logic       out_ready_i;
    logic       flush_i;

    logic       fifo_pop_o;
    logic       out_valid_o;
    logic [0:0] out_data_o;
    logic [1:0] occupancy_o;
    logic [7:0] delivered_o;

    logic       pop_w;
    logic       valid_w;
    logic [0:0] data_w;
    logic [1:0] occ_w;
    logic [1:0] delivered_w;

    int total;
    int bad;

    logic       q[$];
    logic       pop_seen;
    logic       words[12];

    fifo_rd_stream #(.DATA_W(1), .CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_pop_data_i (fifo_pop_data_i),
        .fifo_pop_o      (fifo_pop_o),
        .out_valid_o     (out_valid_o),
        .out_data_o      (out_data_o),
        .out_ready_i     (out_ready_i),
        .flush_i         (flush_i),
        .occupancy_o     (occupancy_o),
        .delivered_o     (delivered_o)
    );

    // Narrow-counter instance sharing the same stimulus, used for wrap checks.
    fifo_rd_stream #(.DATA_W(1), .CNT_W(2)) dut_w (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_pop_data_i (fifo_pop_data_i),
        .fifo_pop_o      (pop_w),
        .out_valid_o     (valid_w),
        .out_data_o      (data_w),
        .out_ready_i     (out_ready_i),
        .flush_i         (flush_i),
        .occupancy_o     (occ_w),
        .delivered_o     (delivered_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fifo_update();
        fifo_empty_i    = (q.size() == 0);
        fifo_pop_data_i = (q.size() != 0) ? q[0] : 1'b0;
    endtask

    // One clock: record whether a pop is offered at the coming edge, take the
    // edge, then retire the popped word from the FIFO model.
    task automatic step();
        #1;
        pop_seen = fifo_pop_o;
        @(posedge clk);
        #1;
        if (pop_seen && q.size() != 0) void'(q.pop_front());
        fifo_update();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        words = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset held two cycles with FIFO non-empty.
        reset       = 1'b1;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        q.push_back(1'b1);
        fifo_update();
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_pop", 32'(pop_seen), 32'd0);
            chk("rst_valid", 32'(out_valid_o), 32'd0);
            chk("rst_deliv", 32'(delivered_o), 32'd0);
            chk("rst_occ", 32'(occupancy_o), 32'd0);
            chk("rst_data", 32'(out_data_o), 32'd0);
        end

        // Single word, consumer ready: pop on the first cycle out of reset.
        reset       = 1'b0;
        out_ready_i = 1'b1;
        step();
        chk("single_pop", 32'(pop_seen), 32'd1);
        chk("single_valid", 32'(out_valid_o), 32'd1);
        chk("single_data", 32'(out_data_o), 32'd1);
        chk("single_deliv0", 32'(delivered_o), 32'd0);
        step();
        chk("single_pop_once", 32'(pop_seen), 32'd0);
        chk("single_valid_off", 32'(out_valid_o), 32'd0);
        chk("single_deliv1", 32'(delivered_o), 32'd1);

        // Backpressure: 1,0,1 queued with ready low.
        out_ready_i = 1'b0;
        q.push_back(1'b1);
        q.push_back(1'b0);
        q.push_back(1'b1);
        fifo_update();
        step();
        chk("bp_pop1", 32'(pop_seen), 32'd1);
        chk("bp_occ1", 32'(occupancy_o), 32'd1);
        step();
        chk("bp_pop2", 32'(pop_seen), 32'd1);
        chk("bp_occ2", 32'(occupancy_o), 32'd2);
        chk("bp_data_hold_a", 32'(out_data_o), 32'd1);
        step();
        chk("bp_no_pop3", 32'(pop_seen), 32'd0);
        chk("bp_occ_full", 32'(occupancy_o), 32'd2);
        chk("bp_data_hold_b", 32'(out_data_o), 32'd1);
        chk("bp_valid", 32'(out_valid_o), 32'd1);
        out_ready_i = 1'b1;
        step();
        chk("bp_xfer1_nopop", 32'(pop_seen), 32'd0);
        chk("bp_data2", 32'(out_data_o), 32'd0);
        chk("bp_deliv2", 32'(delivered_o), 32'd2);
        step();
        chk("bp_pop3", 32'(pop_seen), 32'd1);
        chk("bp_data3", 32'(out_data_o), 32'd1);
        chk("bp_occ_after", 32'(occupancy_o), 32'd1);
        chk("bp_deliv3", 32'(delivered_o), 32'd3);
        step();
        chk("bp_drained", 32'(out_valid_o), 32'd0);
        chk("bp_deliv4", 32'(delivered_o), 32'd4);

        // Streaming: FIFO stays non-empty, one pop and one transfer per cycle.
        for (int i = 0; i < 12; i++) q.push_back(words[i]);
        fifo_update();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stream_pop", 32'(pop_seen), 32'd1);
            chk("stream_occ", 32'(occupancy_o), 32'd1);
            chk("stream_data", 32'(out_data_o), 32'(words[i]));
            chk("stream_deliv", 32'(delivered_o), 32'(4 + i));
        end
        step();
        chk("stream_deliv_final", 32'(delivered_o), 32'd14);
        chk("stream_data_last", 32'(out_data_o), 32'(words[10]));

        // Flush with skid full and ready low.
        out_ready_i = 1'b0;
        step();
        chk("fl_occ2", 32'(occupancy_o), 32'd2);
        chk("fl_head", 32'(out_data_o), 32'(words[10]));
        flush_i = 1'b1;
        step();
        chk("fl_no_pop", 32'(pop_seen), 32'd0);
        chk("fl_valid", 32'(out_valid_o), 32'd0);
        chk("fl_occ0", 32'(occupancy_o), 32'd0);
        chk("fl_deliv", 32'(delivered_o), 32'd14);
        flush_i = 1'b0;
        q.push_back(1'b0);
        fifo_update();
        step();
        chk("fl_resume_pop", 32'(pop_seen), 32'd1);
        chk("fl_resume_valid", 32'(out_valid_o), 32'd1);
        chk("fl_resume_data", 32'(out_data_o), 32'd0);
        // Handshake coinciding with flush still counts.
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        step();
        chk("fl_xfer_nopop", 32'(pop_seen), 32'd0);
        chk("fl_xfer_valid", 32'(out_valid_o), 32'd0);
        chk("fl_xfer_deliv", 32'(delivered_o), 32'd15);
        flush_i = 1'b0;

        // Counter wrap on the 2-bit instance after a mid-run reset.
        reset = 1'b1;
        step();
        chk("wrap_rst", 32'(delivered_w), 32'd0);
        chk("wrap_rst_main", 32'(delivered_o), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) q.push_back(words[i]);
        fifo_update();
        step();
        chk("wrap_first_pop", 32'(delivered_w), 32'd0);
        for (int i = 0; i < 5; i++) begin
            logic [1:0] seq [5];
            seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            step();
            chk("wrap_seq", 32'(delivered_w), 32'(seq[i]));
            chk("wrap_main", 32'(delivered_o), 32'(i + 1));
        end
        chk("wrap_idle", 32'(valid_w), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
